// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access encodings, FSM
// states and the alignment helper used by the top level.
package dm_pkg;

    typedef enum logic [2:0] {
        WORD   = 3'd0,
        HALF_U = 3'd1,
        HALF_S = 3'd2,
        BYTE_U = 3'd3,
        BYTE_S = 3'd4
    } dm_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    function automatic logic dm_op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    // Byte ops are always aligned; illegal ops are reported separately.
    function automatic logic dm_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            WORD:           mis = (addr_lo != 2'b00);
            HALF_U, HALF_S: mis = addr_lo[0];
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Lane steering for the data memory: merges right-aligned store data into
// the stored word and extracts/extends the addressed lane for loads.
module dm_lane
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        merged = word;
        case (op)
            WORD: merged = wdata;
            HALF_U, HALF_S: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            BYTE_U, BYTE_S: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = word;
        endcase
    end

    always_comb begin
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        load_data = 32'd0;
        case (op)
            WORD:    load_data = word;
            HALF_U:  load_data = {16'd0, half_sel};
            HALF_S:  load_data = {{16{half_sel[15]}}, half_sel};
            BYTE_U:  load_data = {24'd0, byte_sel};
            BYTE_S:  load_data = {{24{byte_sel[7]}}, byte_sel};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dm_slave.sv
// Stallable data-memory responder: one outstanding load/store, fixed
// programmable latency, valid/ready request and response channels.
module dm_slave
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqOp,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    input  logic [31:0] reqPc,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respRData,
    output logic        respErr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    dm_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        mem_q [DEPTH];

    logic                  in_idle;
    logic                  acc_wr;
    logic [2:0]            acc_op;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [31:0]           acc_pc;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_err;
    logic                  do_access;
    logic                  mem_we;
    logic [31:0]           old_word;
    logic [31:0]           merged_word;
    logic [31:0]           load_data;

    // With LATENCY=1 the access happens on the accept edge, so the live
    // request is used in IDLE; afterwards the latched copy is used.
    assign in_idle   = (state_q == IDLE);
    assign acc_wr    = in_idle ? reqWrite : wr_q;
    assign acc_op    = in_idle ? reqOp    : op_q;
    assign acc_addr  = in_idle ? reqAddr  : addr_q;
    assign acc_wdata = in_idle ? reqWData : wdata_q;
    assign acc_pc    = in_idle ? reqPc    : pc_q;
    assign acc_idx   = acc_addr[ADDR_WIDTH+1:2];
    assign old_word  = mem_q[acc_idx];

    assign acc_err = !dm_op_legal(acc_op)
                   || dm_misaligned(acc_op, acc_addr[1:0])
                   || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    dm_lane u_lane (
        .word      (old_word),
        .wdata     (acc_wdata),
        .op        (acc_op),
        .addr_lo   (acc_addr[1:0]),
        .merged    (merged_word),
        .load_data (load_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pc_d      = pc_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    wr_d    = reqWrite;
                    op_d    = reqOp;
                    addr_d  = reqAddr;
                    wdata_d = reqWData;
                    pc_d    = reqPc;
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d     = '0;
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (respReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_wr) ? 32'd0 : load_data;
        end
    end

    assign mem_we = do_access && acc_wr && !acc_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        pc_q    <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else if (mem_we) begin
            mem_q[acc_idx] <= merged_word;
        end
    end

`ifndef SYNTHESIS
    // Store trace, emitted on the edge the store commits.
    always_ff @(posedge clk) begin
        if (!reset && mem_we)
            $display("@%08h: *%08h <= %08h", acc_pc, acc_addr & ~32'h3, merged_word);
    end
`endif

    assign reqReady  = (state_q == IDLE);
    assign respValid = (state_q == RESP);
    assign respRData = rdata_q;
    assign respErr   = err_q;

endmodule
